// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the serial nibble subtractor.
package serial_sub_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/subtractor_4bit.sv
// Combinational 4-bit subtractor slice: o_diff = i_a - i_b - i_bin, o_bout = borrow-out.
module subtractor_4bit
  import serial_sub_pkg::*;
(
  input  logic [NIBBLE_W-1:0] i_a,
  input  logic [NIBBLE_W-1:0] i_b,
  input  logic                i_bin,
  output logic [NIBBLE_W-1:0] o_diff,
  output logic                o_bout
);

  logic [NIBBLE_W:0] w_full;

  // The extra top bit of a widened subtraction is exactly the borrow-out.
  assign w_full = {1'b0, i_a} - {1'b0, i_b} - {{NIBBLE_W{1'b0}}, i_bin};
  assign o_diff = w_full[NIBBLE_W-1:0];
  assign o_bout = w_full[NIBBLE_W];

endmodule

// File: rtl/serial_nibble_subtractor.sv
// Multi-cycle a - b - bin, one nibble per clock, LSB first, with valid/ready on both sides.
// Optional zero/ovf result flags are enabled by defining SERIAL_SUB_FLAGS_EN.
module serial_nibble_subtractor
  import serial_sub_pkg::*;
#(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [NIBBLE_W*NIBBLES-1:0]  a,
  input  logic [NIBBLE_W*NIBBLES-1:0]  b,
  input  logic                         bin,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NIBBLE_W*NIBBLES-1:0]  diff,
  output logic                         bout,
`ifdef SERIAL_SUB_FLAGS_EN
  output logic                         zero,
  output logic                         ovf,
`endif
  output logic                         busy
);

  localparam int unsigned W    = NIBBLE_W * NIBBLES;
  localparam int unsigned CntW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  state_e          r_state, w_state_nxt;
  logic [W-1:0]    r_a, w_a_nxt;
  logic [W-1:0]    r_b, w_b_nxt;
  logic [W-1:0]    r_diff, w_diff_nxt;
  logic            r_borrow, w_borrow_nxt;
  logic            r_bout, w_bout_nxt;
  logic [CntW-1:0] r_cnt, w_cnt_nxt;
`ifdef SERIAL_SUB_FLAGS_EN
  logic            r_zero, w_zero_nxt;
  logic            r_ovf, w_ovf_nxt;
`endif

  logic [CntW+1:0]     w_base;
  logic                w_last;
  logic [NIBBLE_W-1:0] w_nib_a, w_nib_b, w_sdiff;
  logic                w_sbout;

  // Bit offset of the current nibble (counter * 4).
  assign w_base  = {r_cnt, 2'b00};
  assign w_last  = (r_cnt == CntW'(NIBBLES - 1));
  assign w_nib_a = r_a[w_base +: NIBBLE_W];
  assign w_nib_b = r_b[w_base +: NIBBLE_W];

  subtractor_4bit u_slice (
    .i_a    (w_nib_a),
    .i_b    (w_nib_b),
    .i_bin  (r_borrow),
    .o_diff (w_sdiff),
    .o_bout (w_sbout)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_a_nxt      = r_a;
    w_b_nxt      = r_b;
    w_diff_nxt   = r_diff;
    w_borrow_nxt = r_borrow;
    w_bout_nxt   = r_bout;
    w_cnt_nxt    = r_cnt;
`ifdef SERIAL_SUB_FLAGS_EN
    w_zero_nxt   = r_zero;
    w_ovf_nxt    = r_ovf;
`endif
    in_ready     = 1'b0;

    unique case (r_state)
      IDLE: in_ready = 1'b1;
      RUN: begin
        w_diff_nxt[w_base +: NIBBLE_W] = w_sdiff;
        w_borrow_nxt                   = w_sbout;
        if (w_last) begin
          w_bout_nxt  = w_sbout;
          w_state_nxt = DONE;
`ifdef SERIAL_SUB_FLAGS_EN
          w_zero_nxt  = (w_diff_nxt == '0);
          w_ovf_nxt   = (r_a[W-1] ^ r_b[W-1]) & (w_diff_nxt[W-1] ^ r_a[W-1]);
`endif
        end else begin
          w_cnt_nxt = r_cnt + CntW'(1);
        end
      end
      DONE: begin
        in_ready = out_ready;
        if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase

    // Handshake overrides the DONE->IDLE exit, giving back-to-back operation.
    if (in_valid && in_ready) begin
      w_a_nxt      = a;
      w_b_nxt      = b;
      w_borrow_nxt = bin;
      w_cnt_nxt    = '0;
      w_diff_nxt   = '0;
      w_bout_nxt   = 1'b0;
`ifdef SERIAL_SUB_FLAGS_EN
      w_zero_nxt   = 1'b0;
      w_ovf_nxt    = 1'b0;
`endif
      w_state_nxt  = RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
      r_bout   <= 1'b0;
      r_cnt    <= '0;
`ifdef SERIAL_SUB_FLAGS_EN
      r_zero   <= 1'b0;
      r_ovf    <= 1'b0;
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_a      <= w_a_nxt;
      r_b      <= w_b_nxt;
      r_diff   <= w_diff_nxt;
      r_borrow <= w_borrow_nxt;
      r_bout   <= w_bout_nxt;
      r_cnt    <= w_cnt_nxt;
`ifdef SERIAL_SUB_FLAGS_EN
      r_zero   <= w_zero_nxt;
      r_ovf    <= w_ovf_nxt;
`endif
    end
  end

  assign out_valid = (r_state == DONE);
  assign busy      = (r_state == RUN);
  assign diff      = r_diff;
  assign bout      = r_bout;
`ifdef SERIAL_SUB_FLAGS_EN
  assign zero      = r_zero;
  assign ovf       = r_ovf;
`endif

endmodule

// File: tb/tb_serial_nibble_subtractor.sv
// Randomized self-checking bench for serial_nibble_subtractor (NIBBLES=4) against an
// arithmetic reference model; flag checks follow SERIAL_SUB_FLAGS_EN.
module tb_serial_nibble_subtractor;

  localparam int unsigned NIB = 4;
  localparam int unsigned W   = 4 * NIB;

  logic         clk, rst_n, in_valid, in_ready, out_valid, out_ready, bin, bout, busy;
  logic [W-1:0] a, b, diff;
`ifdef SERIAL_SUB_FLAGS_EN
  logic         zero, ovf;
`endif

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  logic [W-1:0] exp_diff;
  logic         exp_bout, exp_zero, exp_ovf;

  serial_nibble_subtractor #(.NIBBLES(NIB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
`ifdef SERIAL_SUB_FLAGS_EN
    .zero      (zero),
    .ovf       (ovf),
`endif
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference: whole-word unsigned subtraction; borrow is the 17th bit.
  task automatic set_expect(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tbin);
    logic [W:0] full;
    full     = {1'b0, ta} - {1'b0, tb_v} - {{W{1'b0}}, tbin};
    exp_diff = full[W-1:0];
    exp_bout = full[W];
    exp_zero = (exp_diff == 0);
    exp_ovf  = (ta[W-1] != tb_v[W-1]) && (exp_diff[W-1] != ta[W-1]);
  endtask

  task automatic check_result(input string tag);
    check_eq({tag, "_diff"}, 32'(diff), 32'(exp_diff));
    check_eq({tag, "_bout"}, 32'(bout), 32'(exp_bout));
`ifdef SERIAL_SUB_FLAGS_EN
    check_eq({tag, "_zero"}, 32'(zero), 32'(exp_zero));
    check_eq({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
`endif
  endtask

  // Called at #1 after a rising edge; returns at #1 after the handshake edge.
  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tbin);
    int guard = 0;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    a = ta; b = tb_v; bin = tbin; in_valid = 1'b1;
    #1;
    check_eq("in_ready_hs", 32'(in_ready), 32'd1);
    set_expect(ta, tb_v, tbin);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
  endtask

  task automatic wait_result(input string tag);
    int n = 0;
    check_eq({tag, "_busy"}, 32'(busy), 32'd1);
    check_eq({tag, "_early_valid"}, 32'(out_valid), 32'd0);
    while (!out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq({tag, "_latency"}, 32'(n), 32'(NIB));
    check_eq({tag, "_valid"}, 32'(out_valid), 32'd1);
    check_result(tag);
  endtask

  task automatic consume(input int stall);
    for (int i = 0; i < stall; i++) begin
      out_ready = 1'b0;
      #1;
      check_eq("stall_in_ready", 32'(in_ready), 32'd0);
      check_eq("stall_valid", 32'(out_valid), 32'd1);
      check_result("stall");
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    #1;
    check_eq("done_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_eq("idle_valid", 32'(out_valid), 32'd0);
    check_eq("idle_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; bin = 1'b0;
    #2;
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_diff", 32'(diff), 32'd0);
    check_eq("rst_bout", 32'(bout), 32'd0);
`ifdef SERIAL_SUB_FLAGS_EN
    check_eq("rst_zero", 32'(zero), 32'd0);
    check_eq("rst_ovf", 32'(ovf), 32'd0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    send(16'h1234, 16'h0034, 1'b0); wait_result("t1"); consume(0);
    send(16'h0000, 16'h0001, 1'b0); wait_result("ripple"); consume(0);
    send(16'h8000, 16'h0000, 1'b1); wait_result("ovf"); consume(1);
    send(16'h5A5A, 16'h5A5A, 1'b0); wait_result("zero"); consume(0);

    // Backpressure, then accept new operands in the same cycle the result leaves.
    send(16'hBEEF, 16'h1234, 1'b1); wait_result("bp");
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      check_eq("bp_in_ready", 32'(in_ready), 32'd0);
      check_eq("bp_valid", 32'(out_valid), 32'd1);
      check_result("bp_hold");
    end
    out_ready = 1'b1; in_valid = 1'b1; a = 16'h0010; b = 16'h0001; bin = 1'b0;
    #1;
    check_eq("b2b_in_ready", 32'(in_ready), 32'd1);
    set_expect(16'h0010, 16'h0001, 1'b0);
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b0;
    wait_result("b2b"); consume(0);

    // Reset mid-RUN after two nibbles.
    send(16'hFFFF, 16'h0001, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_busy", 32'(busy), 32'd0);
    check_eq("mid_rst_valid", 32'(out_valid), 32'd0);
    check_eq("mid_rst_diff", 32'(diff), 32'd0);
    check_eq("mid_rst_bout", 32'(bout), 32'd0);
    check_eq("mid_rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("post_rst_in_ready", 32'(in_ready), 32'd1);
    send(16'h4321, 16'h1111, 1'b1); wait_result("post_rst"); consume(0);

    // in_valid while busy must be ignored.
    send(16'h7000, 16'h0800, 1'b0);
    in_valid = 1'b1; a = 16'hAAAA; b = 16'h1111; bin = 1'b1;
    wait_result("ignore");
    in_valid = 1'b0;
    consume(0);

    for (int i = 0; i < 24; i++) begin
      send(W'($urandom), W'($urandom), 1'($urandom));
      wait_result("rand");
      consume(int'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/serial_nibble_subtractor.md
Name: serial_nibble_subtractor

Overview:
- Multi-cycle wide subtractor that computes a − b − bin over NIBBLES×4 bits, one nibble per clock, LSB nibble first.
- Drives the team's existing 4-bit subtractor slice (subtractor_4bit) and consumes its Diff/Bout outputs.
- Registers each nibble result and carries the borrow between cycles.
- Sits between an operand producer (valid/ready) and a result consumer (valid/ready). It is the sequencing stage wrapped around the combinational 4-bit slice.

Parameters:
- NIBBLES, 4, number of 4-bit slices per operand; operand width W = 4*NIBBLES; legal range 1..16

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand transfer request
- in_ready  output  1  block can accept operands this cycle
- a  input  W  minuend, sampled on input handshake
- b  input  W  subtrahend, sampled on input handshake
- bin  input  1  borrow-in, sampled on input handshake
- out_valid  output  1  diff/bout valid
- out_ready  input  1  consumer accepts result
- diff  output  W  registered a − b − bin modulo 2^W
- bout  output  1  registered final borrow-out (1 when a < b + bin, unsigned)
- busy  output  1  high in RUN state

Behaviour:
- Clocking and reset: one clock, clk. Reset is rst_n, asynchronous, active-low.
- Reset values: state=IDLE, in_ready=1 (combinational from state), out_valid=0, diff=0, bout=0, busy=0, nibble counter=0, borrow register=0, operand registers=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: latch a, b, bin into operand/borrow registers, clear counter, go to RUN.
- RUN:
  - Each cycle, slice inputs = a_reg[4k+3:4k], b_reg[4k+3:4k], borrow_reg, where k = counter.
  - Write the slice Diff into diff[4k+3:4k] and the slice Bout into borrow_reg, then increment counter.
  - When k == NIBBLES−1, write the slice Bout into bout and go to DONE.
  - in_ready=0 throughout RUN.
- DONE:
  - out_valid=1.
  - diff/bout held stable until out_ready=1.
  - On out_ready:
    - if in_valid is also high, accept the new operands in the same cycle and go to RUN (back-to-back);
    - otherwise go to IDLE.
  - in_ready = out_ready while in DONE.
- Latency: input handshake in cycle T → out_valid high from cycle T+NIBBLES+1. Throughput is one result per NIBBLES+1 cycles with no backpressure.
- diff is cleared to 0 on the input handshake, so partial results are never visible as valid.
- NIBBLES=1: RUN lasts exactly one cycle. Counter width is max(1, $clog2(NIBBLES)), and no wrap logic is needed beyond the terminal compare.
- Counter never wraps: the terminal compare exits RUN before overflow.
- in_valid while busy is ignored: no latch, no error.
- Reset asserted mid-RUN or mid-DONE: immediate abort to reset values; the pending result is lost. The first cycle after deassertion is IDLE.
- Inputs a, b, bin may change freely outside the handshake cycle.

Optional Feature:
- Macro: SERIAL_SUB_FLAGS_EN
- Defined:
  - Adds outputs zero (1 bit) and ovf (1 bit), both registered and valid with out_valid.
  - zero = 1 when diff == 0.
  - ovf = signed two's-complement overflow, computed as (a[W−1] ≠ b[W−1]) & (diff[W−1] ≠ a[W−1]).
  - Both reset to 0 and hold in DONE.
- Undefined: the ports are absent and no flag logic is synthesised. All other behaviour is identical.

Decomposition:
- Shared package serial_sub_pkg:
  - NIBBLE_W = 4
  - state typedef enum {IDLE, RUN, DONE}, 2-bit encoding
- Sub-module: one instance of the existing subtractor_4bit as the datapath slice. All sequencing, registers and flags stay in serial_nibble_subtractor.

Test Plan (NIBBLES=4):
- a=0x1234, b=0x0034, bin=0, out_ready=1 → diff=0x1200, bout=0; out_valid rises exactly 5 cycles after the handshake.
- a=0x0000, b=0x0001, bin=0 → diff=0xFFFF, bout=1. The borrow must ripple through all four nibbles. With flags: zero=0, ovf=0.
- a=0x8000, b=0x0000, bin=1 → diff=0x7FFF, bout=0. With flags: ovf=1. Then a=0x5A5A, b=0x5A5A → diff=0x0000, zero=1.
- Backpressure:
  - Hold out_ready=0 for 7 cycles after out_valid. diff/bout/out_valid must stay stable and in_ready=0.
  - Then pulse out_ready together with in_valid (a=0x0010, b=0x0001). The new operands are accepted the same cycle, giving diff=0x000F.
- Pulse rst_n low during RUN (after 2 nibbles of a=0xFFFF, b=0x0001) → all outputs at reset values immediately; after release, in_ready=1 and the next operation's result is correct.
- in_valid held high during RUN with different operands → ignored; the result reflects only the originally latched operands.
